mips_multi_cycle_core: RTL and testbench

MIPS_MULTI_CYCLE_CORE -- requirements
Module: mips_multi_cycle_core

---
 rtl/mips_multi_cycle_core.sv | 149 ++++++++++++++
 tb/tb_mips_multi_cycle_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_cycle_core.sv
// Multi-cycle MIPS subset core (lw, sw, R-type add/sub/and/or/slt, beq, addi, j)
// with an internal FSM controller, a 32-entry register file and one
// memory-mapped GPIO output register.
module mips_multi_cycle_core #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     RESET_PC   = '0,
  parameter int unsigned          GPIO_WIDTH = 8,
  parameter logic [WIDTH-1:0]     GPIO_ADDR  = WIDTH'(32'hFFFF_FFF0)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WIDTH-1:0]      mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [3:0]            state_o,
  output logic [WIDTH-1:0]      pc_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        pc_q, a_q, b_q, data_q, alu_out_q;
  logic [31:0]             ir_q;
  logic [GPIO_WIDTH-1:0]   gpio_q;
  logic [WIDTH-1:0]        rf_q [32];

  logic [5:0]              opcode, funct;
  logic [4:0]              rs, rt, rd;
  logic [WIDTH-1:0]        imm_ext, alu_res;
  logic                    is_gpio;
  logic                    unused_shamt;

  assign opcode  = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign imm_ext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign unused_shamt = ^ir_q[10:6];

  assign is_gpio   = (alu_out_q == GPIO_ADDR);
  assign mem_addr  = (state_q == StMemRd || state_q == StMemWr) ? alu_out_q : pc_q;
  assign mem_wdata = b_q;
  // Reset gates the strobe so a store caught by reset never reaches memory.
  assign mem_we    = rst && (state_q == StMemWr) && !is_gpio;
  assign gpio_o    = gpio_q;
  assign state_o   = state_q;
  assign pc_o      = pc_q;

  // R-type ALU; unknown funct codes fall back to add.
  always_comb begin
    alu_res = a_q + b_q;
    case (funct)
      6'b100010: alu_res = a_q - b_q;
      6'b100100: alu_res = a_q & b_q;
      6'b100101: alu_res = a_q | b_q;
      6'b101010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default:   ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StFetch;
    else      state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  // Datapath registers, register file and GPIO, updated per current state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      alu_out_q <= '0;
      gpio_q    <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          ir_q <= mem_rdata[31:0];
          pc_q <= pc_q + WIDTH'(4);
        end
        StDecode: begin
          a_q       <= rf_q[rs];
          b_q       <= rf_q[rt];
          alu_out_q <= pc_q + (imm_ext << 2);
        end
        StMemAdr, StAddiEx: alu_out_q <= a_q + imm_ext;
        StMemRd:  data_q <= mem_rdata;
        StMemWb:  if (rt != 5'd0) rf_q[rt] <= data_q;
        StMemWr:  if (is_gpio) gpio_q <= b_q[GPIO_WIDTH-1:0];
        StExec:   alu_out_q <= alu_res;
        StAluWb:  if (rd != 5'd0) rf_q[rd] <= alu_out_q;
        StAddiWb: if (rt != 5'd0) rf_q[rt] <= alu_out_q;
        StBranch: if (a_q == b_q) pc_q <= alu_out_q;
        StJump:   pc_q <= {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi_cycle_core.sv
// Directed bench for mips_multi_cycle_core: one 32-bit and one 64-bit instance,
// each with a small word-addressed memory model.
module tb_mips_multi_cycle_core;

  logic        clk;
  logic        rst32, rst64;
  logic [31:0] addr32, wdata32, rdata32, pc32;
  logic        we32;
  logic [7:0]  gpio32;
  logic [3:0]  state32;
  logic [63:0] addr64, wdata64, rdata64, pc64;
  logic        we64;
  logic [7:0]  gpio64;
  logic [3:0]  state64;

  logic [31:0] mem32 [128];
  logic [63:0] mem64 [128];
  logic        ld_we32, ld_we64;
  logic [31:0] ld_addr;
  logic [63:0] ld_data;

  int          wcnt32, wcnt64;
  logic [63:0] waddr32, wdat32, waddr64, wdat64;
  int          checks, errors;

  mips_multi_cycle_core #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst32), .mem_addr(addr32), .mem_wdata(wdata32), .mem_we(we32),
    .mem_rdata(rdata32), .gpio_o(gpio32), .state_o(state32), .pc_o(pc32)
  );

  mips_multi_cycle_core #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst64), .mem_addr(addr64), .mem_wdata(wdata64), .mem_we(we64),
    .mem_rdata(rdata64), .gpio_o(gpio64), .state_o(state64), .pc_o(pc64)
  );

  assign rdata32 = mem32[addr32[8:2]];
  assign rdata64 = mem64[addr64[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we32) begin
      mem32[addr32[8:2]] <= wdata32;
      wcnt32  <= wcnt32 + 1;
      waddr32 <= 64'(addr32);
      wdat32  <= 64'(wdata32);
    end else if (ld_we32) begin
      mem32[ld_addr[8:2]] <= ld_data[31:0];
    end
  end

  always @(posedge clk) begin
    if (we64) begin
      mem64[addr64[8:2]] <= wdata64;
      wcnt64  <= wcnt64 + 1;
      waddr64 <= addr64;
      wdat64  <= wdata64;
    end else if (ld_we64) begin
      mem64[ld_addr[8:2]] <= ld_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input bit w64, input logic [31:0] addr, input logic [63:0] data);
    ld_addr = addr;
    ld_data = data;
    ld_we32 = !w64;
    ld_we64 = w64;
    step(1);
    ld_we32 = 1'b0;
    ld_we64 = 1'b0;
  endtask

  // Runs one instruction from FETCH to the next FETCH and checks its latency.
  task automatic run(input bit w64, input int exp_n, input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while ((w64 ? state64 : state32) != 4'd0 && n < 12);
    chk({tag, " cycles"}, 64'(n), 64'(exp_n));
  endtask

  int          pw32_a [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 64,
                               65, 66};
  logic [31:0] pw32_d [20] = '{32'h2001_0005, 32'h2002_FFFD, 32'h0022_1820, 32'hAC03_0008,
                               32'h1021_0002, 32'hFC00_0000, 32'hFC00_0000, 32'h8C04_0008,
                               32'h0041_282A, 32'h0022_3022, 32'h0022_3824, 32'h0022_4025,
                               32'h2009_00A5, 32'hAC09_FFF0, 32'hFC00_0000, 32'h2000_0007,
                               32'h0800_0040, 32'h1022_0002, 32'hAC01_000C, 32'hFC00_0000};
  int          pw64_a [8] = '{0, 1, 2, 3, 4, 5, 6, 64};
  logic [31:0] pw64_d [8] = '{32'h2001_FFFD, 32'h2002_0005, 32'h0022_282A, 32'h0022_1820,
                              32'hAC03_0080, 32'h8C04_0080, 32'h0800_0040, 32'hAC02_0084};

  initial begin
    int c;
    checks = 0; errors = 0;
    wcnt32 = 0; wcnt64 = 0;
    rst32 = 1'b0; rst64 = 1'b0;
    ld_we32 = 1'b0; ld_we64 = 1'b0; ld_addr = '0; ld_data = '0;
    step(2);
    for (int i = 0; i < 20; i++) load(1'b0, 32'(pw32_a[i] * 4), 64'(pw32_d[i]));
    for (int i = 0; i < 8; i++)  load(1'b1, 32'(pw64_a[i] * 4), 64'(pw64_d[i]));

    // Reset state
    chk("rst state32", 64'(state32), 64'd0);
    chk("rst pc32", 64'(pc32), 64'd0);
    chk("rst gpio32", 64'(gpio32), 64'd0);
    chk("rst we32", 64'(we32), 64'd0);
    chk("rst state64", 64'(state64), 64'd0);
    chk("rst pc64", pc64, 64'd0);

    // ---------------- 32-bit core ----------------
    rst32 = 1'b1;
    run(1'b0, 4, "addi1");
    chk("addi1 r1", 64'(dut32.rf_q[1]), 64'd5);
    chk("addi1 pc", 64'(pc32), 64'h4);
    run(1'b0, 4, "addi2");
    chk("addi2 r2", 64'(dut32.rf_q[2]), 64'hFFFF_FFFD);
    run(1'b0, 4, "add");
    chk("add r3", 64'(dut32.rf_q[3]), 64'd2);
    run(1'b0, 4, "sw");
    chk("sw pulses", 64'(wcnt32), 64'd1);
    chk("sw addr", waddr32, 64'h8);
    chk("sw data", wdat32, 64'h2);
    run(1'b0, 3, "beq taken");
    chk("beq taken pc", 64'(pc32), 64'h1C);
    run(1'b0, 5, "lw");
    chk("lw r4", 64'(dut32.rf_q[4]), 64'd2);
    run(1'b0, 4, "slt");
    chk("slt r5", 64'(dut32.rf_q[5]), 64'd1);
    run(1'b0, 4, "sub");
    chk("sub r6", 64'(dut32.rf_q[6]), 64'd8);
    run(1'b0, 4, "and");
    chk("and r7", 64'(dut32.rf_q[7]), 64'd5);
    run(1'b0, 4, "or");
    chk("or r8", 64'(dut32.rf_q[8]), 64'hFFFF_FFFD);
    run(1'b0, 4, "addi9");
    c = wcnt32;
    run(1'b0, 4, "sw gpio");
    chk("gpio value", 64'(gpio32), 64'hA5);
    chk("gpio no we", 64'(wcnt32), 64'(c));
    run(1'b0, 2, "nop");
    chk("nop pc", 64'(pc32), 64'h3C);
    chk("nop r1", 64'(dut32.rf_q[1]), 64'd5);
    chk("nop r9", 64'(dut32.rf_q[9]), 64'hA5);
    run(1'b0, 4, "addi r0");
    chk("r0 zero", 64'(dut32.rf_q[0]), 64'd0);
    run(1'b0, 3, "j");
    chk("j pc", 64'(pc32), 64'h100);
    run(1'b0, 3, "beq not taken");
    chk("beq nt pc", 64'(pc32), 64'h104);
    // Reset while a store sits in MEMWR
    c = wcnt32;
    step(3);
    chk("at memwr32", 64'(state32), 64'd5);
    chk("memwr we32", 64'(we32), 64'd1);
    rst32 = 1'b0;
    #1;
    chk("we32 in reset", 64'(we32), 64'd0);
    step(1);
    chk("memwr rst state", 64'(state32), 64'd0);
    chk("memwr rst pc", 64'(pc32), 64'd0);
    chk("memwr rst gpio", 64'(gpio32), 64'd0);
    chk("memwr rst no store", 64'(wcnt32), 64'(c));
    chk("memwr rst r1", 64'(dut32.rf_q[1]), 64'd0);
    load(1'b0, 32'h8, 64'h0022_1820);
    // Reset while an add sits in EXEC
    rst32 = 1'b1;
    run(1'b0, 4, "re addi1");
    run(1'b0, 4, "re addi2");
    step(2);
    chk("at exec32", 64'(state32), 64'd6);
    rst32 = 1'b0;
    step(1);
    chk("exec rst state", 64'(state32), 64'd0);
    chk("exec rst pc", 64'(pc32), 64'd0);
    step(2);
    chk("exec rst r3", 64'(dut32.rf_q[3]), 64'd0);
    chk("exec rst r1", 64'(dut32.rf_q[1]), 64'd0);
    rst32 = 1'b1;
    run(1'b0, 4, "post rst addi");
    chk("post rst pc", 64'(pc32), 64'h4);
    chk("post rst r1", 64'(dut32.rf_q[1]), 64'd5);
    rst32 = 1'b0;

    // ---------------- 64-bit core ----------------
    rst64 = 1'b1;
    run(1'b1, 4, "w64 addi1");
    chk("w64 r1", dut64.rf_q[1], 64'hFFFF_FFFF_FFFF_FFFD);
    run(1'b1, 4, "w64 addi2");
    run(1'b1, 4, "w64 slt");
    chk("w64 slt r5", dut64.rf_q[5], 64'd1);
    run(1'b1, 4, "w64 add");
    chk("w64 add r3", dut64.rf_q[3], 64'd2);
    run(1'b1, 4, "w64 sw");
    chk("w64 sw pulses", 64'(wcnt64), 64'd1);
    chk("w64 sw addr", waddr64, 64'h80);
    chk("w64 sw data", wdat64, 64'h2);
    run(1'b1, 5, "w64 lw");
    chk("w64 lw r4", dut64.rf_q[4], 64'd2);
    run(1'b1, 3, "w64 j");
    chk("w64 j pc", pc64, 64'h100);
    c = wcnt64;
    step(3);
    chk("at memwr64", 64'(state64), 64'd5);
    rst64 = 1'b0;
    #1;
    chk("we64 in reset", 64'(we64), 64'd0);
    step(1);
    chk("w64 memwr rst state", 64'(state64), 64'd0);
    chk("w64 memwr rst pc", pc64, 64'd0);
    chk("w64 memwr rst gpio", 64'(gpio64), 64'd0);
    chk("w64 memwr rst no store", 64'(wcnt64), 64'(c));
    chk("w64 memwr rst r2", dut64.rf_q[2], 64'd0);
    rst64 = 1'b1;
    run(1'b1, 4, "w64 re addi1");
    run(1'b1, 4, "w64 re addi2");
    step(2);
    chk("at exec64", 64'(state64), 64'd6);
    rst64 = 1'b0;
    step(1);
    chk("w64 exec rst state", 64'(state64), 64'd0);
    chk("w64 exec rst pc", pc64, 64'd0);
    step(2);
    chk("w64 exec rst r5", dut64.rf_q[5], 64'd0);
    rst64 = 1'b1;
    run(1'b1, 4, "w64 post rst addi");
    chk("w64 post rst pc", pc64, 64'h4);
    chk("w64 post rst r1", dut64.rf_q[1], 64'hFFFF_FFFF_FFFF_FFFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
